// File: rtl/sha_pkg.sv
// ---------------------------------------------------------------------------
// sha_pkg
// Shared definitions for the SHA-256 block and its UART output path.
//   DIGEST_W         width of a finished digest
//   UART_FRAME_BITS  bits per 8N1 frame (start + 8 data + stop)
//   BYTE_CNT_W       width of the digest byte counter
//   uart_tx_state_t  states of the single-byte UART transmitter
//   digest_seq_t     states of the digest byte sequencer
//   top_byte()       most significant byte of a digest-wide word
// ---------------------------------------------------------------------------
package sha_pkg;

  localparam int DIGEST_W        = 256;
  localparam int UART_FRAME_BITS = 10;
  localparam int BYTE_CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } digest_seq_t;

  function automatic logic [7:0] top_byte(input logic [DIGEST_W-1:0] word);
    return word[DIGEST_W-1 -: 8];
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// Single-byte 8N1 UART transmitter, LSB first, line idle high.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   byte_valid   a byte is offered on byte_data
//   byte_data    byte to send
//   byte_ready   byte is taken this cycle if byte_valid is high
//                (high in IDLE and in the final cycle of STOP)
//   frame_done   final cycle of the stop bit
//   tx           registered UART line
// A byte offered during the last STOP cycle starts its start bit on the very
// next cycle, so back-to-back bytes go out with no gap.
// ---------------------------------------------------------------------------
module uart_tx_core
  import sha_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       frame_done,
  output logic       tx
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  uart_tx_state_t    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;   // remaining bits, current bit at [0]
  logic              tx_q, tx_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + BAUD_ONE;
    bit_d   = bit_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (byte_valid) begin
          state_d = START;
          data_d  = byte_data;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d  = bit_q + 3'd1;
            data_d = data_q >> 1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (byte_valid) begin
            state_d = START;
            data_d  = byte_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; tx is precomputed from the next state so the line is a flop
  always_comb begin
    byte_ready = (state_q == IDLE) || ((state_q == STOP) && baud_last);
    frame_done = (state_q == STOP) && baud_last;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: rtl/uart_digest_tx.sv
// ---------------------------------------------------------------------------
// uart_digest_tx
// Sends a 256-bit SHA-256 digest on the UART line as DIGEST_BYTES
// back-to-back 8N1 frames, most significant byte first.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   ena            enables acceptance of a new digest (not needed to finish)
//   digest         digest word, byte 0 = digest[255:248]
//   digest_valid   digest offered
//   digest_ready   block is idle and can take a digest
//   tx             UART line (idle high)
//   busy           transfer in progress
//   done           one-cycle pulse after the last stop bit
// The first byte is handed to the core straight from the digest input on
// the accept edge, so the start bit appears on the next cycle; the shift
// register therefore keeps the digest already advanced by one byte.
// ---------------------------------------------------------------------------
module uart_digest_tx
  import sha_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DIGEST_BYTES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                digest_valid,
  output logic                digest_ready,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(DIGEST_BYTES - 1);

  digest_seq_t           seq_q, seq_d;
  logic [DIGEST_W-1:0]   shift_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic                  done_q;

  logic       accept;
  logic       last_byte;
  logic       more;
  logic       handoff;
  logic       finish;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       frame_done;

  assign accept     = digest_valid && digest_ready && ena;
  assign last_byte  = (byte_cnt_q == LAST_BYTE);
  assign more       = (seq_q == SEQ_SEND) && !last_byte;
  assign handoff    = more && byte_ready;
  assign finish     = (seq_q == SEQ_SEND) && frame_done && last_byte;
  assign byte_valid = accept || more;
  assign byte_data  = (seq_q == SEQ_IDLE) ? top_byte(digest) : top_byte(shift_q);

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .frame_done(frame_done),
    .tx        (tx)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= SEQ_IDLE;
    else        seq_q <= seq_d;
  end

  // Sequencer next state
  always_comb begin
    seq_d = seq_q;
    unique case (seq_q)
      SEQ_IDLE: if (accept) seq_d = SEQ_SEND;
      SEQ_SEND: if (finish) seq_d = SEQ_IDLE;
      default:  seq_d = SEQ_IDLE;
    endcase
  end

  // Sequencer outputs, decoded from the state flop only
  always_comb begin
    digest_ready = (seq_q == SEQ_IDLE);
    busy         = (seq_q == SEQ_SEND);
  end

  // Digest shift register, byte counter and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        shift_q    <= {digest[DIGEST_W-9:0], 8'h00};
        byte_cnt_q <= '0;
      end else if (handoff) begin
        shift_q    <= {shift_q[DIGEST_W-9:0], 8'h00};
        byte_cnt_q <= byte_cnt_q + 5'd1;
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_uart_digest_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_digest_tx
// Directed bench for uart_digest_tx with CLKS_PER_BIT=4. The tx line is
// captured every cycle of a transfer (sampled on the falling edge), then
// compared cycle-by-cycle against a frame model and decoded mid-bit.
// ---------------------------------------------------------------------------
module tb_uart_digest_tx;

  localparam int CPB   = 4;
  localparam int NB    = 32;
  localparam int T_END = 10 * NB * CPB + 1;   // cycle index of the done pulse

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic         tx;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic       cap [1:T_END];
  logic [7:0] rx_bytes [NB];

  typedef struct {
    logic [255:0] d;
    logic [7:0]   first_b;
    logic [7:0]   last_b;
  } vec_t;

  vec_t vecs [4];

  localparam logic [255:0] ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] RAMP = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  uart_digest_tx #(
    .CLKS_PER_BIT(CPB),
    .DIGEST_BYTES(NB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .digest      (digest),
    .digest_valid(digest_valid),
    .digest_ready(digest_ready),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected line level in cycle t (t=1 is the first start-bit cycle)
  function automatic logic exp_line(input logic [255:0] d, input int t);
    int         k;
    int         b;
    int         j;
    logic [7:0] by;
    k  = (t - 1) / CPB;
    b  = k / 10;
    j  = k % 10;
    by = d[255 - 8*b -: 8];
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return by[j-1];
  endfunction

  // One digest transfer. pre_acc: valid/digest already driven and the next
  // rising edge is the accept edge. collide_at: cycle at which an all-ones
  // digest is offered. abort_at: cycle at which reset is pulsed.
  task automatic run_transfer(input logic [255:0] d, input bit pre_acc,
                              input int collide_at, input int abort_at,
                              input string tag);
    int         w;
    int         done_bad;
    int         line_bad;
    int         frame_err;
    int         dbad;
    logic [7:0] by;
    done_bad = 0;
    if (!pre_acc) begin
      @(negedge clk);
      digest       = d;
      digest_valid = 1'b1;
      ena          = 1'b1;
      w = 0;
      while (!digest_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (!digest_ready) begin
        chki({tag, "_ready_wait"}, w, 0);
        digest_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    for (int t = 1; t <= T_END; t++) begin
      @(negedge clk);
      if (t == 1) begin
        digest_valid = 1'b0;
        chk1({tag, "_ready_low"}, digest_ready, 1'b0);
        chk1({tag, "_busy_high"}, busy, 1'b1);
        chk1({tag, "_start_bit"}, tx, 1'b0);
        chk1({tag, "_done_low"}, done, 1'b0);
      end
      if (t == collide_at) begin
        digest       = '1;
        digest_valid = 1'b1;
      end
      if (t == abort_at) begin
        chk1({tag, "_pre_abort_tx"}, tx, exp_line(d, t));
        #1 rst_n = 1'b0;
        #1;
        chk1({tag, "_async_tx"}, tx, 1'b1);
        chk1({tag, "_async_ready"}, digest_ready, 1'b1);
        chk1({tag, "_async_busy"}, busy, 1'b0);
        chk1({tag, "_async_done"}, done, 1'b0);
        dbad = 0;
        repeat (3) begin
          @(negedge clk);
          if (done !== 1'b0 || tx !== 1'b1) dbad++;
        end
        chki({tag, "_in_reset"}, dbad, 0);
        rst_n = 1'b1;
        return;
      end
      cap[t] = tx;
      if (t < T_END && done !== 1'b0) done_bad++;
    end
    chki({tag, "_early_done"}, done_bad, 0);
    chk1({tag, "_done_pulse"}, done, 1'b1);
    chk1({tag, "_done_ready"}, digest_ready, 1'b1);
    chk1({tag, "_done_busy"}, busy, 1'b0);

    line_bad = 0;
    for (int t = 1; t < T_END; t++)
      if (cap[t] !== exp_line(d, t)) line_bad++;
    chki({tag, "_line_cycles"}, line_bad, 0);

    frame_err = 0;
    for (int b = 0; b < NB; b++) begin
      if (cap[(b*10)*CPB + 2] !== 1'b0 || cap[(b*10 + 9)*CPB + 2] !== 1'b1) frame_err++;
      for (int j = 0; j < 8; j++) by[j] = cap[(b*10 + 1 + j)*CPB + 2];
      rx_bytes[b] = by;
      chk8($sformatf("%s_byte%0d", tag, b), by, d[255 - 8*b -: 8]);
    end
    chki({tag, "_framing"}, frame_err, 0);
  endtask

  logic [9:0] ff_pat;
  int         bad;

  initial begin
    vecs[0] = '{ABC,    8'hBA, 8'hAD};
    vecs[1] = '{'0,     8'h00, 8'h00};
    vecs[2] = '{'1,     8'hFF, 8'hFF};
    vecs[3] = '{RAMP,   8'h00, 8'h1F};
    ff_pat  = 10'b0010111011;   // 0xBA framed: start, LSB..MSB, stop

    rst_n        = 1'b0;
    ena          = 1'b0;
    digest_valid = 1'b0;
    digest       = '0;

    // Reset values with the clock running, then after release
    repeat (3) @(negedge clk);
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_ready", digest_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rel_tx", tx, 1'b1);
    chk1("rel_ready", digest_ready, 1'b1);
    chk1("rel_busy", busy, 1'b0);
    chk1("rel_done", done, 1'b0);

    // Table of digests
    for (int i = 0; i < 4; i++) begin
      run_transfer(vecs[i].d, 1'b0, 0, 0, $sformatf("vec%0d", i));
      chk8($sformatf("vec%0d_first", i), rx_bytes[0], vecs[i].first_b);
      chk8($sformatf("vec%0d_last", i), rx_bytes[NB-1], vecs[i].last_b);
      if (i == 0) begin
        bad = 0;
        for (int j = 0; j < 10; j++)
          if (cap[j*CPB + 2] !== ff_pat[9-j]) bad++;
        chki("abc_first_frame", bad, 0);
      end
    end

    // Digest offered while busy: ignored, then taken on the done cycle
    run_transfer(ABC, 1'b0, 5*10*CPB + 10, 0, "collide");
    run_transfer('1, 1'b1, 0, 0, "after_collide");

    // Reset during a data bit of byte 10, then a fresh transfer
    run_transfer(RAMP, 1'b0, 0, 10*10*CPB + CPB + 2, "abort");
    run_transfer(ABC, 1'b0, 0, 0, "post_abort");

    // ena low blocks acceptance; raising it accepts on the next edge
    @(negedge clk);
    ena          = 1'b0;
    digest       = '0;
    digest_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || digest_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    chki("ena_gate", bad, 0);
    ena = 1'b1;
    run_transfer('0, 1'b1, 0, 0, "ena");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
